asm_mem_resp: RTL and testbench
===============================

# asm_mem_resp

Responder end of the accelerator-domain stall-based memory port (en/wben/addr/wdata in, rdata/stall out). It sits between the port arbiter output and a synchronous single-port SRAM macro with fixed multi-cycle read latency. It converts SRAM latency into stall cycles and serves writes without stall. It holds each read's data in a register until the next read completes.

## Interface
- MEM_DATAWIDTH, 128, data word width
- MEM_ADDRWIDTH, 14, word address width
- MEM_BSELWIDTH, MEM_DATAWIDTH/8, byte-enable width
- RD_LATENCY, 2, SRAM read latency in cycles (legal 1..8)
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- mem_en_i  in  1  request valid; held stable with wben/addr/wdata while mem_stall_o=1
- mem_wben_i  in  MEM_BSELWIDTH  byte write enables; all-zero means read
- mem_addr_i  in  MEM_ADDRWIDTH  word address
- mem_wdata_i  in  MEM_DATAWIDTH  write data
- mem_rdata_o  out  MEM_DATAWIDTH  read data, valid in the read completion cycle, held afterwards
- mem_stall_o  out  1  request not completed this cycle
- hold_i  in  1  blocks new SRAM accesses (init/power management)
- sram_en_o  out  1  SRAM access strobe
- sram_wben_o  out  MEM_BSELWIDTH  SRAM byte write enables
- sram_addr_o  out  MEM_ADDRWIDTH  SRAM address
- sram_wdata_o  out  MEM_DATAWIDTH  SRAM write data
- sram_rdata_i  in  MEM_DATAWIDTH  SRAM read data, valid RD_LATENCY cycles after the strobe

## Operation
- FSM states: IDLE, RD_WAIT, RD_DONE. A down-counter lat_cnt is 4 bits wide.
- A transfer completes in any cycle with mem_en_i=1 and mem_stall_o=0.
- IDLE, hold_i=1:
  - sram_en_o=0.
  - mem_stall_o=mem_en_i.
- IDLE, hold_i=0, mem_en_i=1, wben≠0 (write):
  - sram_en_o=1, sram_wben_o=mem_wben_i, addr and wdata passed through.
  - mem_stall_o=0; the write completes the same cycle. Stay in IDLE.
- IDLE, hold_i=0, mem_en_i=1, wben=0 (read):
  - sram_en_o=1, sram_wben_o=0.
  - mem_stall_o=1.
  - lat_cnt←RD_LATENCY-1, go to RD_WAIT.
- RD_WAIT:
  - sram_en_o=0, mem_stall_o=1.
  - If lat_cnt=0: rdata_q←sram_rdata_i, go to RD_DONE. Otherwise decrement lat_cnt.
- RD_DONE:
  - mem_stall_o=0; the read completes. Go to IDLE unconditionally.
  - No new SRAM access is issued in this cycle.
- mem_rdata_o=rdata_q at all times. Writes never change rdata_q.
- hold_i is sampled only in IDLE. An in-flight read always finishes.
- mem_en_i dropping during RD_WAIT or RD_DONE is a protocol violation. The FSM still runs to IDLE and rdata_q is updated; nothing else happens. An SVA flags it.
- sram_addr_o, sram_wdata_o and sram_wben_o are don't-care when sram_en_o=0. The implementation drives them from the inputs.

## Timing
- Reset values:
  - state=IDLE, lat_cnt=0, rdata_q=0, so mem_rdata_o=0.
  - sram_en_o=0 and mem_stall_o=0 when mem_en_i=0 and hold_i=0.
- Write: 0 stall cycles, completes in cycle T.
- Read issued at T:
  - mem_stall_o=1 for cycles T..T+RD_LATENCY.
  - Completes at T+RD_LATENCY+1.
  - Occupancy is RD_LATENCY+2 cycles including the completion cycle.
- Back-to-back: the next request is accepted in the cycle after completion. A write after a read issues at T+RD_LATENCY+2.
- Reset asserted mid-read:
  - Immediately returns to IDLE and clears rdata_q.
  - SRAM data still in flight is ignored, because the FSM only samples in RD_WAIT.
- All outputs other than rdata are combinational from state, mem_en_i, mem_wben_i and hold_i. mem_stall_o has no path from the sram_* inputs.

## Structure
- Shared package asm_mem_pkg holds:
  - the state enum (IDLE, RD_WAIT, RD_DONE);
  - LAT_CNT_W=4;
  - a function is_read(wben) returning wben==0.
- The existing arbiter shares these definitions.
- No sub-module. The counter and FSM are inline.
- An elaboration-time check rejects RD_LATENCY outside 1..8.

## Test plan
- Write with mem_en_i=1, wben=16'hFFFF, addr=0x010, wdata=A5…A5: mem_stall_o=0 the same cycle; sram_en_o=1 and sram_wben_o=FFFF at T.
- Read of addr 0x010 with RD_LATENCY=2, SRAM model returning A5…A5: mem_stall_o=1 for 3 cycles; mem_rdata_o=A5…A5 with stall=0 at T+3; value held after mem_en_i drops.
- Partial write with wben=16'h0001 and data 0x5A, then read: the SRAM model shows only byte 0 changed; the read returns the merged word.
- hold_i=1 with a read pending for 5 cycles: sram_en_o=0 and mem_stall_o=1 throughout. After hold_i drops, the read completes RD_LATENCY+1 cycles later.
- reset_i pulse during RD_WAIT: next cycle state=IDLE, mem_rdata_o=0, mem_stall_o=0 with en=0. A new read afterwards returns correct data, not the stale in-flight data.
- Sweep RD_LATENCY=1 and 8 with random back-to-back read/write traffic against a scoreboard: every read returns the last written bytes, and the stall count per read equals RD_LATENCY+1.

Source files
------------

// File: rtl/asm_mem_pkg.sv
// Definitions shared by the accelerator memory-port responder and arbiter.
package asm_mem_pkg;

    localparam int LAT_CNT_W  = 4;
    // Widest byte-enable vector any port instance may use.
    localparam int BSEL_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_e;

    function automatic logic is_read(input logic [BSEL_MAX_W-1:0] wben);
        return (wben == '0);
    endfunction

endpackage

// File: rtl/asm_mem_resp.sv
// Responder for the stall-based memory port: turns fixed SRAM read latency
// into stall cycles, serves writes in one cycle and holds the last read word.
module asm_mem_resp
    import asm_mem_pkg::*;
#(
    parameter int MEM_DATAWIDTH = 128,
    parameter int MEM_ADDRWIDTH = 14,
    parameter int MEM_BSELWIDTH = MEM_DATAWIDTH / 8,
    parameter int RD_LATENCY    = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     mem_en_i,
    input  logic [MEM_BSELWIDTH-1:0] mem_wben_i,
    input  logic [MEM_ADDRWIDTH-1:0] mem_addr_i,
    input  logic [MEM_DATAWIDTH-1:0] mem_wdata_i,
    output logic [MEM_DATAWIDTH-1:0] mem_rdata_o,
    output logic                     mem_stall_o,
    input  logic                     hold_i,
    output logic                     sram_en_o,
    output logic [MEM_BSELWIDTH-1:0] sram_wben_o,
    output logic [MEM_ADDRWIDTH-1:0] sram_addr_o,
    output logic [MEM_DATAWIDTH-1:0] sram_wdata_o,
    input  logic [MEM_DATAWIDTH-1:0] sram_rdata_i
);

    if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
        $error("asm_mem_resp: RD_LATENCY must be within 1..8");
    end
    if (MEM_BSELWIDTH > BSEL_MAX_W) begin : g_bad_bsel
        $error("asm_mem_resp: MEM_BSELWIDTH exceeds BSEL_MAX_W");
    end

    state_e                   state_q, state_d;
    logic [LAT_CNT_W-1:0]     lat_cnt_q, lat_cnt_d;
    logic [MEM_DATAWIDTH-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        rdata_d     = rdata_q;
        sram_en_o   = 1'b0;
        mem_stall_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hold_i) begin
                    mem_stall_o = mem_en_i;
                end else if (mem_en_i) begin
                    sram_en_o = 1'b1;
                    if (is_read(BSEL_MAX_W'(mem_wben_i))) begin
                        mem_stall_o = 1'b1;
                        lat_cnt_d   = LAT_CNT_W'(RD_LATENCY - 1);
                        state_d     = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                mem_stall_o = 1'b1;
                if (lat_cnt_q == '0) begin
                    rdata_d = sram_rdata_i;
                    state_d = RD_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address/data/enables are don't-care while sram_en_o=0, so pass them straight through.
    assign sram_wben_o  = mem_wben_i;
    assign sram_addr_o  = mem_addr_i;
    assign sram_wdata_o = mem_wdata_i;
    assign mem_rdata_o  = rdata_q;

    a_en_held_mid_read : assert property (
        @(posedge clk_i) disable iff (reset_i) (state_q != IDLE) |-> mem_en_i
    ) else $error("asm_mem_resp: mem_en_i dropped while a read was in flight");

endmodule

// File: tb/tb_asm_mem_resp.sv
// Bench for asm_mem_resp: directed vector table at RD_LATENCY=2 plus
// scoreboarded read/write traffic at RD_LATENCY=1 and 8.
module tb_asm_mem_resp;

    localparam logic [127:0] A5  = {16{8'hA5}};
    localparam logic [127:0] MRG = {{15{8'hA5}}, 8'h5A};
    localparam logic [127:0] P3  = {4{32'h12345678}};
    localparam logic [127:0] C3  = {16{8'hC3}};
    localparam logic [127:0] D96 = {16{8'h96}};

    typedef struct {
        logic         en;
        logic         hold;
        logic [15:0]  wben;
        logic [13:0]  addr;
        logic [127:0] wdata;
        logic         x_stall;
        logic         x_sen;
        logic [127:0] x_rdata;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ndone  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 8);

        logic         rst = 1'b1;
        logic         en = 1'b0, hold = 1'b0;
        logic [15:0]  wben = '0;
        logic [13:0]  addr = '0;
        logic [127:0] wdata = '0;
        logic [127:0] rdata, swdata, srdata;
        logic         stall, sen;
        logic [15:0]  swben;
        logic [13:0]  saddr;

        asm_mem_resp #(
            .MEM_DATAWIDTH(128),
            .MEM_ADDRWIDTH(14),
            .MEM_BSELWIDTH(16),
            .RD_LATENCY   (LAT)
        ) dut (
            .clk_i       (clk),
            .reset_i     (rst),
            .mem_en_i    (en),
            .mem_wben_i  (wben),
            .mem_addr_i  (addr),
            .mem_wdata_i (wdata),
            .mem_rdata_o (rdata),
            .mem_stall_o (stall),
            .hold_i      (hold),
            .sram_en_o   (sen),
            .sram_wben_o (swben),
            .sram_addr_o (saddr),
            .sram_wdata_o(swdata),
            .sram_rdata_i(srdata)
        );

        // SRAM model: byte-masked write, read data valid exactly LAT cycles after the strobe.
        logic [127:0] mem  [16];
        logic [127:0] pipe [LAT];
        always @(posedge clk) begin
            pipe[0] <= {4{32'hDEADBEEF}};
            if (sen) begin
                pipe[0] <= mem[saddr[3:0]];
                for (int b = 0; b < 16; b++)
                    if (swben[b]) mem[saddr[3:0]][8*b +: 8] <= swdata[8*b +: 8];
            end
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign srdata = pipe[LAT-1];

        task automatic do_reset();
            rst = 1'b1; en = 1'b0; hold = 1'b0; wben = '0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
        endtask

        task automatic do_write(input logic [13:0] a, input logic [15:0] be, input logic [127:0] d);
            @(negedge clk);
            en = 1'b1; hold = 1'b0; wben = be; addr = a; wdata = d;
            #1;
            chk("wr_stall", 128'(stall), 128'(1'b0));
            chk("wr_sram_en", 128'(sen), 128'(1'b1));
        endtask

        task automatic do_read(input logic [13:0] a, input logic [127:0] exp);
            int n;
            @(negedge clk);
            en = 1'b1; hold = 1'b0; wben = '0; addr = a;
            n = 0;
            #1;
            while (stall && n < 40) begin
                n++;
                @(negedge clk);
                #1;
            end
            chk("rd_stall_cycles", 128'(n), 128'(LAT + 1));
            chk("rd_data", rdata, exp);
        endtask

        if (g == 0) begin : dir
            initial begin
                vec_t tv [27];
                tv[0]  = '{1'b0, 1'b0, 16'h0000, 14'h000, 128'h0, 1'b0, 1'b0, 128'h0};
                tv[1]  = '{1'b1, 1'b0, 16'hFFFF, 14'h010, A5,     1'b0, 1'b1, 128'h0};
                tv[2]  = '{1'b1, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b1, 1'b1, 128'h0};
                tv[3]  = '{1'b1, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b1, 1'b0, 128'h0};
                tv[4]  = '{1'b1, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b1, 1'b0, 128'h0};
                tv[5]  = '{1'b1, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b0, 1'b0, A5};
                tv[6]  = '{1'b0, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b0, 1'b0, A5};
                tv[7]  = '{1'b1, 1'b0, 16'h0001, 14'h010, 128'h5A, 1'b0, 1'b1, A5};
                tv[8]  = '{1'b1, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b1, 1'b1, A5};
                tv[9]  = '{1'b1, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b1, 1'b0, A5};
                tv[10] = '{1'b1, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b1, 1'b0, A5};
                tv[11] = '{1'b1, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b0, 1'b0, MRG};
                tv[12] = '{1'b0, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b0, 1'b0, MRG};
                for (int i = 13; i <= 17; i++)
                    tv[i] = '{1'b1, 1'b1, 16'h0000, 14'h010, 128'h0, 1'b1, 1'b0, MRG};
                tv[18] = '{1'b1, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b1, 1'b1, MRG};
                tv[19] = '{1'b1, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b1, 1'b0, MRG};
                tv[20] = '{1'b1, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b1, 1'b0, MRG};
                tv[21] = '{1'b1, 1'b0, 16'h0000, 14'h010, 128'h0, 1'b0, 1'b0, MRG};
                tv[22] = '{1'b1, 1'b0, 16'hFFFF, 14'h003, P3,     1'b0, 1'b1, MRG};
                tv[23] = '{1'b0, 1'b1, 16'h0000, 14'h003, 128'h0, 1'b0, 1'b0, MRG};
                tv[24] = '{1'b1, 1'b1, 16'hFFFF, 14'h003, P3,     1'b1, 1'b0, MRG};
                tv[25] = '{1'b1, 1'b0, 16'hFFFF, 14'h003, P3,     1'b0, 1'b1, MRG};
                tv[26] = '{1'b0, 1'b0, 16'h0000, 14'h000, 128'h0, 1'b0, 1'b0, MRG};

                do_reset();
                for (int i = 0; i < 27; i++) begin
                    if (i > 0) @(negedge clk);
                    en = tv[i].en; hold = tv[i].hold; wben = tv[i].wben;
                    addr = tv[i].addr; wdata = tv[i].wdata;
                    #1;
                    chk($sformatf("v%0d_stall", i), 128'(stall), 128'(tv[i].x_stall));
                    chk($sformatf("v%0d_sram_en", i), 128'(sen), 128'(tv[i].x_sen));
                    chk($sformatf("v%0d_rdata", i), rdata, tv[i].x_rdata);
                    if (tv[i].x_sen) begin
                        chk($sformatf("v%0d_sram_wben", i), 128'(swben), 128'(tv[i].wben));
                        chk($sformatf("v%0d_sram_addr", i), 128'(saddr), 128'(tv[i].addr));
                    end
                end
                chk("sram_partial_merge", mem[4'h0], MRG);
                chk("sram_full_write", mem[4'h3], P3);

                // Reset pulse while a read is waiting on the SRAM.
                do_write(14'h005, 16'hFFFF, C3);
                do_write(14'h006, 16'hFFFF, D96);
                do_read(14'h006, D96);
                @(negedge clk);
                en = 1'b1; wben = '0; addr = 14'h005;
                #1;
                chk("rst_issue_stall", 128'(stall), 128'(1'b1));
                @(negedge clk);
                en = 1'b0; rst = 1'b1;
                #1;
                chk("rst_rdata", rdata, 128'h0);
                chk("rst_stall", 128'(stall), 128'(1'b0));
                chk("rst_sram_en", 128'(sen), 128'(1'b0));
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("post_rst_stall", 128'(stall), 128'(1'b0));
                chk("post_rst_rdata", rdata, 128'h0);
                do_read(14'h006, D96);
                do_write(14'h006, 16'h8000, 128'hBB << 120);
                do_read(14'h006, {8'hBB, {15{8'h96}}});
                do_read(14'h005, C3);
                @(negedge clk);
                en = 1'b0;
                ndone++;
            end
        end else begin : rnd
            initial begin
                logic [127:0] sb [16];
                logic [127:0] d;
                logic [15:0]  be;
                logic [3:0]   a;
                do_reset();
                for (int i = 0; i < 16; i++) begin
                    d = {$urandom, $urandom, $urandom, $urandom};
                    sb[i] = d;
                    do_write(14'(i), 16'hFFFF, d);
                end
                for (int k = 0; k < 48; k++) begin
                    a = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 1) == 0) begin
                        do_read(14'(a), sb[a]);
                    end else begin
                        d  = {$urandom, $urandom, $urandom, $urandom};
                        be = 16'($urandom_range(1, 65535));
                        for (int b = 0; b < 16; b++)
                            if (be[b]) sb[a][8*b +: 8] = d[8*b +: 8];
                        do_write(14'(a), be, d);
                    end
                end
                @(negedge clk);
                en = 1'b0;
                ndone++;
            end
        end
    end

    initial begin
        int c;
        c = 0;
        while (ndone < 3 && c < 20000) begin
            @(posedge clk);
            c++;
        end
        if (ndone < 3) chk("all_done_timeout", 128'(ndone), 128'(3));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
